// File: rtl/sc_screen_select_gen.sv
// Screen-content select/data producer: blank -> flash -> random LFSR rows -> blink -> blank.
// Define SC_SCREENSEL_PAUSE_EN to add a pause input that freezes the RUN pattern.
module sc_screen_select_gen #(
  parameter int unsigned SELECTWIDTH     = 8,
  parameter int unsigned FLASH_TICKS     = 4,
  parameter int unsigned RAND_PERIOD     = 2,
  parameter int unsigned GAMEOVER_BLINKS = 6,
  parameter logic [7:0]  LFSR_SEED       = 8'h01
) (
  input  logic                   SC_SCREENSEL_CLOCK_50,
  input  logic                   SC_SCREENSEL_RESET_InHigh,
  input  logic                   SC_SCREENSEL_tick_InHigh,
  input  logic                   SC_SCREENSEL_start_InHigh,
  input  logic                   SC_SCREENSEL_crash_InHigh,
`ifdef SC_SCREENSEL_PAUSE_EN
  input  logic                   SC_SCREENSEL_pause_InHigh,
`endif
  output logic [SELECTWIDTH-1:0] SC_SCREENSEL_select_OutBUS,
  output logic [SELECTWIDTH-1:0] SC_SCREENSEL_data_OutBUS,
  output logic                   SC_SCREENSEL_newdata_OutHigh,
  output logic [1:0]             SC_SCREENSEL_state_OutBUS
);

  localparam logic [1:0] StClear    = 2'd0;
  localparam logic [1:0] StFlash    = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;
  localparam logic [1:0] StGameover = 2'd3;

  localparam logic [7:0] FlashLast = 8'(FLASH_TICKS - 1);
  localparam logic [7:0] RandLast  = 8'(RAND_PERIOD - 1);
  localparam logic [7:0] BlinkLast = 8'(GAMEOVER_BLINKS - 1);
  // A zero seed would lock the LFSR in its dead state.
  localparam logic [7:0] SeedEff   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [1:0] r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [7:0] r_lfsr, w_lfsr;
  logic [1:0] r_select, w_select;
  logic       r_newdata, w_newdata;
  logic       w_run_tick;

`ifdef SC_SCREENSEL_PAUSE_EN
  assign w_run_tick = SC_SCREENSEL_tick_InHigh & ~SC_SCREENSEL_pause_InHigh;
`else
  assign w_run_tick = SC_SCREENSEL_tick_InHigh;
`endif

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_lfsr    = r_lfsr;
    w_select  = r_select;
    w_newdata = 1'b0;
    case (r_state)
      StClear: begin
        w_select = 2'd0;
        if (SC_SCREENSEL_start_InHigh) begin
          w_state  = StFlash;
          w_lfsr   = SeedEff;
          w_cnt    = 8'd0;
          w_select = 2'd1;
        end
      end
      StFlash: begin
        if (SC_SCREENSEL_crash_InHigh) begin
          w_state  = StGameover;
          w_cnt    = 8'd0;
          w_select = 2'd1;
        end else if (SC_SCREENSEL_tick_InHigh) begin
          if (r_cnt == FlashLast) begin
            w_state  = StRun;
            w_cnt    = 8'd0;
            w_select = 2'd2;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
      end
      StRun: begin
        if (SC_SCREENSEL_crash_InHigh) begin
          w_state  = StGameover;
          w_cnt    = 8'd0;
          w_select = 2'd1;
        end else if (w_run_tick) begin
          if (r_cnt == RandLast) begin
            w_lfsr    = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            w_cnt     = 8'd0;
            w_newdata = 1'b1;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
      end
      StGameover: begin
        if (SC_SCREENSEL_tick_InHigh) begin
          if (r_cnt == BlinkLast) begin
            w_state  = StClear;
            w_cnt    = 8'd0;
            w_select = 2'd0;
          end else begin
            w_cnt    = r_cnt + 8'd1;
            w_select = {1'b0, ~r_select[0]};
          end
        end
      end
      default: begin
        w_state  = StClear;
        w_cnt    = 8'd0;
        w_select = 2'd0;
      end
    endcase
  end

  always_ff @(posedge SC_SCREENSEL_CLOCK_50 or posedge SC_SCREENSEL_RESET_InHigh) begin
    if (SC_SCREENSEL_RESET_InHigh) begin
      r_state   <= StClear;
      r_cnt     <= 8'd0;
      r_lfsr    <= 8'd0;
      r_select  <= 2'd0;
      r_newdata <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_lfsr    <= w_lfsr;
      r_select  <= w_select;
      r_newdata <= w_newdata;
    end
  end

  always_comb begin
    SC_SCREENSEL_select_OutBUS      = '0;
    SC_SCREENSEL_select_OutBUS[1:0] = r_select;
    SC_SCREENSEL_data_OutBUS        = '0;
    SC_SCREENSEL_data_OutBUS[7:0]   = r_lfsr;
  end

  assign SC_SCREENSEL_newdata_OutHigh = r_newdata;
  assign SC_SCREENSEL_state_OutBUS    = r_state;

endmodule

// File: tb/tb_sc_screen_select_gen.sv
// Table-driven bench for sc_screen_select_gen plus hand sequences for async reset and pause.
module tb_sc_screen_select_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, start, crash;
`ifdef SC_SCREENSEL_PAUSE_EN
  logic       pause;
`endif
  logic [7:0] sel, data;
  logic       nd;
  logic [1:0] st;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       tick;
    logic       start;
    logic       crash;
    logic [7:0] sel;
    logic [7:0] data;
    logic       nd;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sc_screen_select_gen dut (
    .SC_SCREENSEL_CLOCK_50       (clk),
    .SC_SCREENSEL_RESET_InHigh   (rst),
    .SC_SCREENSEL_tick_InHigh    (tick),
    .SC_SCREENSEL_start_InHigh   (start),
    .SC_SCREENSEL_crash_InHigh   (crash),
`ifdef SC_SCREENSEL_PAUSE_EN
    .SC_SCREENSEL_pause_InHigh   (pause),
`endif
    .SC_SCREENSEL_select_OutBUS  (sel),
    .SC_SCREENSEL_data_OutBUS    (data),
    .SC_SCREENSEL_newdata_OutHigh(nd),
    .SC_SCREENSEL_state_OutBUS   (st)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_sel, input logic [7:0] e_data,
                         input logic e_nd, input logic [1:0] e_st);
    chk({tag, " select"}, sel, e_sel);
    chk({tag, " data"}, data, e_data);
    chk({tag, " newdata"}, {7'd0, nd}, {7'd0, e_nd});
    chk({tag, " state"}, {6'd0, st}, {6'd0, e_st});
  endtask

  task automatic add(input logic t, input logic s, input logic c, input logic [7:0] e_sel,
                     input logic [7:0] e_data, input logic e_nd, input logic [1:0] e_st);
    vec_t v;
    v.tick = t; v.start = s; v.crash = c;
    v.sel = e_sel; v.data = e_data; v.nd = e_nd; v.st = e_st;
    tbl.push_back(v);
  endtask

  // Drive inputs mid-cycle, clock once, sample just after the edge.
  task automatic cycle(input logic t, input logic s, input logic c);
    @(negedge clk);
    tick = t; start = s; crash = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; crash = 1'b0;
`ifdef SC_SCREENSEL_PAUSE_EN
    pause = 1'b0;
`endif
    #12;
    chk_all("reset", 8'd0, 8'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    //  tick start crash | sel  data   nd state
    add(0, 1, 0, 8'd1, 8'h01, 0, 2'd1);   // start -> FLASH, seed loaded
    add(1, 0, 0, 8'd1, 8'h01, 0, 2'd1);
    add(1, 1, 0, 8'd1, 8'h01, 0, 2'd1);   // start ignored in FLASH
    add(1, 0, 0, 8'd1, 8'h01, 0, 2'd1);
    add(1, 0, 0, 8'd2, 8'h01, 0, 2'd2);   // 4th tick -> RUN
    add(0, 0, 0, 8'd2, 8'h01, 0, 2'd2);
    add(1, 0, 0, 8'd2, 8'h01, 0, 2'd2);
    add(1, 0, 0, 8'd2, 8'h02, 1, 2'd2);
    add(0, 0, 0, 8'd2, 8'h02, 0, 2'd2);
    add(1, 0, 0, 8'd2, 8'h02, 0, 2'd2);
    add(1, 0, 0, 8'd2, 8'h04, 1, 2'd2);
    add(1, 0, 0, 8'd2, 8'h04, 0, 2'd2);
    add(1, 0, 0, 8'd2, 8'h08, 1, 2'd2);
    add(1, 0, 0, 8'd2, 8'h08, 0, 2'd2);
    add(1, 0, 0, 8'd2, 8'h11, 1, 2'd2);   // feedback bit kicks in
    add(0, 1, 0, 8'd2, 8'h11, 0, 2'd2);   // start ignored in RUN
    add(1, 0, 0, 8'd2, 8'h11, 0, 2'd2);
    add(1, 1, 1, 8'd1, 8'h11, 0, 2'd3);   // crash beats due advance
    add(1, 0, 0, 8'd0, 8'h11, 0, 2'd3);
    add(1, 1, 0, 8'd1, 8'h11, 0, 2'd3);   // start ignored in GAMEOVER
    add(0, 0, 1, 8'd1, 8'h11, 0, 2'd3);
    add(1, 0, 0, 8'd0, 8'h11, 0, 2'd3);
    add(1, 0, 0, 8'd1, 8'h11, 0, 2'd3);
    add(1, 0, 0, 8'd0, 8'h11, 0, 2'd3);
    add(1, 0, 0, 8'd0, 8'h11, 0, 2'd0);   // 6th blink tick -> CLEAR
    add(0, 0, 1, 8'd0, 8'h11, 0, 2'd0);   // crash ignored in CLEAR
    add(1, 0, 0, 8'd0, 8'h11, 0, 2'd0);
    add(0, 1, 0, 8'd1, 8'h01, 0, 2'd1);
    add(0, 0, 1, 8'd1, 8'h01, 0, 2'd3);   // crash from FLASH

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].tick, tbl[i].start, tbl[i].crash);
      chk_all($sformatf("row%0d", i), tbl[i].sel, tbl[i].data, tbl[i].nd, tbl[i].st);
    end

    // Async reset mid-RUN: outputs clear without any clock edge.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);   // finish GAMEOVER
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk_all("pre_reset", 8'd2, 8'h02, 1'b1, 2'd2);
    @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all("async_reset", 8'd0, 8'd0, 1'b0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_held", 8'd0, 8'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    chk_all("post_reset", 8'd0, 8'd0, 1'b0, 2'd0);

`ifdef SC_SCREENSEL_PAUSE_EN
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    chk_all("pause_run", 8'd2, 8'h01, 1'b0, 2'd2);
    @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      chk_all($sformatf("paused%0d", i), 8'd2, 8'h01, 1'b0, 2'd2);
    end
    @(negedge clk);
    pause = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    chk_all("resume1", 8'd2, 8'h01, 1'b0, 2'd2);
    cycle(1'b1, 1'b0, 1'b0);
    chk_all("resume2", 8'd2, 8'h02, 1'b1, 2'd2);
    @(negedge clk);
    pause = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    chk_all("pause_crash", 8'd1, 8'h02, 1'b0, 2'd3);
    @(negedge clk);
    pause = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_screen_select_gen.md
Name: sc_screen_select_gen

Overview:
- Sequential producer for the screen-content selector interface: it generates the select code and the random row data that the screen mux consumes.
- Select codes: 0 = blank, 1 = all-on/flash, 2 = random data.
- Sits between the game-control inputs (start, crash, prescaler tick) and the screen mux.
- Sequences blank → ready flash → running random pattern → game-over blink → blank.

Parameters:
- SELECTWIDTH, 8, width of select and data buses; LFSR logic uses bits [7:0], upper bits driven 0.
- FLASH_TICKS, 4, ticks spent in FLASH before RUN (legal range 1..255).
- RAND_PERIOD, 2, ticks between LFSR advances in RUN (legal range 1..255).
- GAMEOVER_BLINKS, 6, ticks of alternating 1/0 in GAMEOVER (legal range 1..255).
- LFSR_SEED, 8'h01, value loaded on start; a value of 0 is replaced by 8'h01.

Ports:
- SC_SCREENSEL_CLOCK_50  in  1  system clock; all state changes on the rising edge.
- SC_SCREENSEL_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_SCREENSEL_tick_InHigh  in  1  one-cycle enable pulse from the prescaler.
- SC_SCREENSEL_start_InHigh  in  1  start-game pulse.
- SC_SCREENSEL_crash_InHigh  in  1  crash/game-over pulse.
- SC_SCREENSEL_select_OutBUS  out  SELECTWIDTH  select code to the screen mux: 0, 1 or 2.
- SC_SCREENSEL_data_OutBUS  out  SELECTWIDTH  random data to the screen mux (LFSR value).
- SC_SCREENSEL_newdata_OutHigh  out  1  one-cycle pulse when data_OutBUS changes in RUN.
- SC_SCREENSEL_state_OutBUS  out  2  debug state code: CLEAR=0, FLASH=1, RUN=2, GAMEOVER=3.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-game): state=CLEAR, select=0, data=0, newdata=0, tick counter=0, LFSR=0.
- CLEAR:
  - select=0.
  - start=1 → FLASH on the next edge; load LFSR with LFSR_SEED (0 → 8'h01); counter=0.
  - crash is ignored.
- FLASH:
  - select=1.
  - Each tick increments the counter.
  - On the edge that samples the FLASH_TICKS-th tick → RUN, counter=0.
  - start is ignored; crash → GAMEOVER (crash has priority).
- RUN:
  - select=2.
  - Each tick increments the counter.
  - On the edge that samples the RAND_PERIOD-th tick: LFSR advances, counter=0, newdata=1 for the following cycle.
  - LFSR step: next = {q[6:0], q[7]^q[5]^q[4]^q[3]}. Period is 255; the all-zero state is never reached.
  - data_OutBUS = LFSR value, zero-extended.
  - crash=1 → GAMEOVER with counter=0, no LFSR advance that edge. crash wins over a same-cycle tick or start.
  - start is ignored.
- GAMEOVER:
  - select starts at 1 and toggles 1↔0 on each tick.
  - After the GAMEOVER_BLINKS-th tick → CLEAR with select=0.
  - start and crash are ignored.
  - data holds its last value.
- newdata is 0 in every state except the single cycle after an LFSR advance.
- tick is a level, sampled per cycle; a tick held high counts once per cycle.
- Counter is 8 bits; it never exceeds the parameter value (resets on match), so no wrap occurs.

Optional Feature:
- Macro SC_SCREENSEL_PAUSE_EN.
- When defined: adds input port SC_SCREENSEL_pause_InHigh (1 bit).
  - While pause=1 in RUN, ticks are ignored: counter and LFSR hold, newdata=0, select stays 2.
  - crash is still honoured during pause.
  - pause has no effect in other states.
- When undefined: the port is absent and RUN behaves as described above.

Test Plan:
- Reset mid-RUN, held 3 cycles → select=0, data=0, newdata=0, state=0 immediately (asynchronous, no clock edge needed).
- start pulse, then 4 ticks (FLASH_TICKS=4) → select=1 for the 4 ticks; state=2 and select=2 on the edge after the 4th tick.
- RUN with RAND_PERIOD=2, seed 8'h01, 8 ticks → data sequence 01→02→04→08→11; newdata pulses exactly 4 times, one cycle each.
- crash and tick asserted in the same cycle as a due LFSR advance → state=3, data unchanged, no newdata pulse.
- GAMEOVER with GAMEOVER_BLINKS=6, 6 ticks → select 1,0,1,0,1,0 then state=0, select=0; a start pulse during GAMEOVER is ignored.
- With SC_SCREENSEL_PAUSE_EN defined: pause=1 for 5 ticks in RUN → data and newdata frozen; release → advances resume after 2 further ticks.
